// File: rtl/fetch_if.sv
// fetch_if: control, redirect, loader and IF/ID-facing signals of the instruction-fetch stage
interface fetch_if #(
  parameter int NB_INSTRUCT = 32,
  parameter int NB_PC       = 9
);
  logic                   start;
  logic                   pc_write;
  logic [1:0]             pc_src;
  logic [NB_PC-1:0]       branch_addr;
  logic [NB_PC-1:0]       jump_addr;
  logic [NB_PC-1:0]       jr_addr;
  logic                   mem_wr_en;
  logic [NB_PC-3:0]       mem_wr_addr;
  logic [NB_INSTRUCT-1:0] mem_wr_data;
  logic [NB_INSTRUCT-1:0] instruction;
  logic [NB_PC-1:0]       pc;
  logic [NB_PC-1:0]       pc_plus4;
  logic                   halt;
  modport master (
    output start, pc_write, pc_src, branch_addr, jump_addr, jr_addr,
           mem_wr_en, mem_wr_addr, mem_wr_data,
    input  instruction, pc, pc_plus4, halt
  );
  modport slave (
    input  start, pc_write, pc_src, branch_addr, jump_addr, jr_addr,
           mem_wr_en, mem_wr_addr, mem_wr_data,
    output instruction, pc, pc_plus4, halt
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, loader-written instruction memory, redirect/stall/HALT handling; IF_STEP_MODE_EN adds i_step single-stepping
module if_fetch_stage #(
  parameter int                     NB_INSTRUCT = 32,
  parameter int                     NB_PC       = 9,
  parameter logic [NB_INSTRUCT-1:0] HALT_CODE   = 32'hFFFF_FFFF
) (
  input  logic     i_clk,
  input  logic     i_reset,
`ifdef IF_STEP_MODE_EN
  input  logic     i_step,
`endif
  fetch_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t                 state, next_state;
  logic [NB_PC-1:0]       pc, next_pc, pc_plus4, target, fetch_pc;
  logic [NB_INSTRUCT-1:0] mem [0:2**(NB_PC-2)-1];
  logic [NB_INSTRUCT-1:0] word;
  logic                   advance, halt_hit;
`ifdef IF_STEP_MODE_EN
  logic                   step_q;
  // remember last i_step sample so only its rising edge advances the PC
  always_ff @(posedge i_clk) step_q <= i_reset ? 1'b0 : i_step;
  assign advance = bus.pc_write & i_step & ~step_q;
`else
  assign advance = bus.pc_write;
`endif
  assign word     = mem[pc[NB_PC-1:2]];
  assign pc_plus4 = pc + NB_PC'(4);
  // loader writes land only while idle; reset takes priority over a write
  always_ff @(posedge i_clk) begin
    if (!i_reset && state == IDLE && bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
  end
  // state and PC registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end
  // next PC selection and HALT detection; a redirect puts a fetched HALT on the wrong path
  always_comb begin
    target     = bus.pc_src == 2'b01 ? bus.branch_addr : bus.pc_src == 2'b10 ? bus.jump_addr : bus.jr_addr;
    fetch_pc   = bus.pc_src == 2'b00 ? pc_plus4 : target & ~NB_PC'(3);
    halt_hit   = state == RUN && advance && bus.pc_src == 2'b00 && word == HALT_CODE;
    next_state = state == IDLE && bus.start ? RUN : halt_hit ? HALT : state;
    next_pc    = state == RUN && advance && !halt_hit ? fetch_pc : pc;
  end
  assign bus.pc       = pc;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.halt     = state == HALT;
`ifdef IF_STEP_MODE_EN
  assign bus.instruction = state == RUN && advance ? word : '0;
`else
  assign bus.instruction = state == RUN ? word : '0;
`endif
endmodule
